// File: rtl/dac_pwm_pkg.sv
// dac_pwm_pkg: shared state enum and default sizing for the PWM DAC transmitter
package dac_pwm_pkg;
  typedef enum logic {IDLE, RUN} state_e;
  localparam int DATA_W_DEF = 10;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PRE_W_DEF = 8;
endpackage

// File: rtl/dac_pwm_if.sv
// dac_pwm_if: sample handshake, control and pad-side signals of the PWM DAC transmitter
interface dac_pwm_if import dac_pwm_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PRE_W = PRE_W_DEF
);
  logic en_i;
  logic [PRE_W-1:0] prescale_i;
  logic [DATA_W-1:0] sample_i;
  logic sample_valid_i;
  logic sample_ready_o;
  logic pwm_o;
  logic pwm_oeb_o;
  logic period_start_o;
  logic underrun_o;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_o;
  modport master (
    output en_i, prescale_i, sample_i, sample_valid_i,
    input sample_ready_o, pwm_o, pwm_oeb_o, period_start_o, underrun_o, fifo_level_o
  );
  modport slave (
    input en_i, prescale_i, sample_i, sample_valid_i,
    output sample_ready_o, pwm_o, pwm_oeb_o, period_start_o, underrun_o, fifo_level_o
  );
endinterface

// File: rtl/dac_pwm_fifo.sv
// dac_pwm_fifo: synchronous sample FIFO with registered full/empty/level
module dac_pwm_fifo import dac_pwm_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [DATA_W-1:0] wdata,
  input  logic pop,
  output logic [DATA_W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic full_q, full_d, empty_q, empty_d, do_push, do_pop;
  always_comb begin
    do_push = push && !full_q;
    do_pop = pop && !empty_q;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    lvl_d = lvl_q + LW'(do_push) - LW'(do_pop);
    full_d = lvl_d == LW'(DEPTH);
    empty_d = lvl_d == '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      lvl_q <= lvl_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign full = full_q;
  assign empty = empty_q;
  assign level = lvl_q;
endmodule

// File: rtl/dac_pwm_tx.sv
// dac_pwm_tx: buffers DAC codes and emits one PWM period per sample on the io pad
module dac_pwm_tx import dac_pwm_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  dac_pwm_if.slave bus
);
  localparam logic [DATA_W-1:0] TICK_MAX = '1;
  state_e state_q, state_d;
  logic [DATA_W-1:0] duty_q, duty_d, tick_q, tick_d, rdata;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d, pre_lat_q, pre_lat_d;
  logic pwm_q, pwm_d, start_q, start_d, unr_q, unr_d;
  logic run, tick, boundary, pop, full, empty;
  logic [$clog2(FIFO_DEPTH):0] level;
  dac_pwm_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(bus.sample_valid_i), .wdata(bus.sample_i),
    .pop(pop), .rdata(rdata), .full(full), .empty(empty), .level(level)
  );
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb state_d = bus.en_i && (state_q == RUN || !empty) ? RUN : IDLE;
  // dropping en_i forces the compare low on the very next edge, not one tick later
  always_comb begin
    run = state_q == RUN && bus.en_i;
    tick = pre_cnt_q == pre_lat_q;
    boundary = run && tick && tick_q == TICK_MAX;
    pop = (state_q == IDLE && state_d == RUN) || (boundary && !empty);
    duty_d = pop ? rdata : duty_q;
    pre_lat_d = pop ? bus.prescale_i : pre_lat_q;
    start_d = pop;
    unr_d = unr_q || (boundary && empty);
    pre_cnt_d = run && !tick ? pre_cnt_q + PRE_W'(1) : '0;
    tick_d = run ? tick_q + DATA_W'(tick) : '0;
    pwm_d = run && tick_q < duty_q;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      duty_q <= '0;
      tick_q <= '0;
      pre_cnt_q <= '0;
      pre_lat_q <= '0;
      pwm_q <= 1'b0;
      start_q <= 1'b0;
      unr_q <= 1'b0;
    end else begin
      duty_q <= duty_d;
      tick_q <= tick_d;
      pre_cnt_q <= pre_cnt_d;
      pre_lat_q <= pre_lat_d;
      pwm_q <= pwm_d;
      start_q <= start_d;
      unr_q <= unr_d;
    end
  end
  assign bus.sample_ready_o = !full;
  assign bus.pwm_o = pwm_q;
  assign bus.pwm_oeb_o = state_q != RUN;
  assign bus.period_start_o = start_q;
  assign bus.underrun_o = unr_q;
  assign bus.fifo_level_o = level;
endmodule

// File: tb/tb_dac_pwm_tx.sv
// tb_dac_pwm_tx: table of per-period duty/prescale vectors plus directed corner sequences
module tb_dac_pwm_tx;
  typedef struct {
    logic [3:0] duty;
    logic [7:0] pre;
    int exp_high;
    int exp_len;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  vec_t tab [7];
  int h, fs, k;
  dac_pwm_if #(.DATA_W(4), .FIFO_DEPTH(4), .PRE_W(8)) bus ();
  dac_pwm_tx #(.DATA_W(4), .FIFO_DEPTH(4), .PRE_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_start(input string name);
    int n = 0;
    while (!bus.period_start_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.period_start_o), 1);
  endtask
  task automatic measure(input int n, input logic [7:0] next_pre, output int high, output int first);
    high = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      high += int'(bus.pwm_o);
      if (bus.period_start_o && first == 0) first = i;
      if (i == n / 2) bus.prescale_i = next_pre;
    end
  endtask
  task automatic push(input logic [3:0] d);
    int n = 0;
    while (!bus.sample_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", int'(bus.sample_ready_o), 1);
    bus.sample_i = d;
    bus.sample_valid_i = 1'b1;
    @(negedge clk);
    bus.sample_valid_i = 1'b0;
  endtask
  initial begin
    tab[0] = '{4'd8, 8'd0, 8, 16};
    tab[1] = '{4'd8, 8'd0, 8, 16};
    tab[2] = '{4'd4, 8'd0, 4, 16};
    tab[3] = '{4'd12, 8'd3, 48, 64};
    tab[4] = '{4'd0, 8'd2, 0, 48};
    tab[5] = '{4'd15, 8'd2, 45, 48};
    tab[6] = '{4'd8, 8'd2, 24, 48};
    bus.en_i = 1'b0;
    bus.prescale_i = '0;
    bus.sample_i = '0;
    bus.sample_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pwm", int'(bus.pwm_o), 0);
    chk("rst_oeb", int'(bus.pwm_oeb_o), 1);
    chk("rst_ready", int'(bus.sample_ready_o), 1);
    chk("rst_start", int'(bus.period_start_o), 0);
    chk("rst_underrun", int'(bus.underrun_o), 0);
    chk("rst_level", int'(bus.fifo_level_o), 0);
    fork
      for (int i = 0; i < 7; i++) push(tab[i].duty);
    join_none
    k = 0;
    while (bus.fifo_level_o != 3'd4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("fill_level", int'(bus.fifo_level_o), 4);
    chk("fill_ready", int'(bus.sample_ready_o), 0);
    chk("idle_oeb", int'(bus.pwm_oeb_o), 1);
    bus.prescale_i = tab[0].pre;
    bus.en_i = 1'b1;
    wait_start("first_start");
    chk("run_oeb", int'(bus.pwm_oeb_o), 0);
    for (int i = 0; i < 7; i++) begin
      measure(tab[i].exp_len, i < 6 ? tab[i+1].pre : tab[i].pre, h, fs);
      chk($sformatf("high%0d", i), h, tab[i].exp_high);
      chk($sformatf("len%0d", i), fs, i < 6 ? tab[i].exp_len : 0);
      chk($sformatf("underrun%0d", i), int'(bus.underrun_o), i == 6 ? 1 : 0);
    end
    measure(48, 8'd2, h, fs);
    chk("repeat_high", h, 24);
    chk("repeat_nostart", fs, 0);
    repeat (3) @(negedge clk);
    chk("pre_rst_pwm", int'(bus.pwm_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pwm", int'(bus.pwm_o), 0);
    chk("arst_oeb", int'(bus.pwm_oeb_o), 1);
    chk("arst_start", int'(bus.period_start_o), 0);
    chk("arst_underrun", int'(bus.underrun_o), 0);
    chk("arst_level", int'(bus.fifo_level_o), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.en_i = 1'b0;
    bus.prescale_i = '0;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.sample_ready_o), 1);
    chk("post_rst_level", int'(bus.fifo_level_o), 0);
    for (int i = 0; i < 4; i++) begin
      bus.sample_i = 4'(12 + i);
      bus.sample_valid_i = 1'b1;
      @(negedge clk);
      chk($sformatf("bp_level%0d", i), int'(bus.fifo_level_o), i + 1);
    end
    chk("bp_ready", int'(bus.sample_ready_o), 0);
    bus.sample_i = 4'd9;
    repeat (3) @(negedge clk);
    chk("bp_hold_level", int'(bus.fifo_level_o), 4);
    chk("bp_hold_ready", int'(bus.sample_ready_o), 0);
    bus.en_i = 1'b1;
    @(negedge clk);
    chk("bp_start", int'(bus.period_start_o), 1);
    chk("bp_pop_level", int'(bus.fifo_level_o), 3);
    chk("bp_pop_ready", int'(bus.sample_ready_o), 1);
    @(negedge clk);
    chk("bp_fifth_level", int'(bus.fifo_level_o), 4);
    chk("bp_fifth_ready", int'(bus.sample_ready_o), 0);
    bus.sample_valid_i = 1'b0;
    @(negedge clk);
    chk("dis_pre_pwm", int'(bus.pwm_o), 1);
    bus.en_i = 1'b0;
    @(negedge clk);
    chk("dis_pwm", int'(bus.pwm_o), 0);
    chk("dis_oeb", int'(bus.pwm_oeb_o), 1);
    chk("dis_level", int'(bus.fifo_level_o), 4);
    bus.en_i = 1'b1;
    @(negedge clk);
    chk("reen_start", int'(bus.period_start_o), 1);
    chk("reen_oeb", int'(bus.pwm_oeb_o), 0);
    chk("reen_level", int'(bus.fifo_level_o), 3);
    measure(16, 8'd0, h, fs);
    chk("reen_high", h, 13);
    chk("reen_len", fs, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
